// File: rtl/wallace_cpa_pipe.sv
// rtl/wallace_cpa_pipe.sv - two-stage elastic carry-propagate adder closing a Wallace tree
module wallace_cpa_pipe #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_sum,
    input  logic [W-1:0] in_carry,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_prod,
    output logic         out_ovf,
    output logic         busy
);
    localparam int LO = W / 2;
    localparam int HI = W - LO;

    logic          v1_q, v1_d;
    logic          v2_q, v2_d;
    logic [LO-1:0] lo1_q, lo1_d;
    logic          c1_q, c1_d;
    logic [HI-1:0] hs1_q, hs1_d;
    logic [HI-1:0] hc1_q, hc1_d;
    logic [W-1:0]  prod_q, prod_d;
    logic          ovf_q, ovf_d;

    logic          s1_load;
    logic          s2_load;
    logic [LO:0]   lo_sum;
    logic [HI:0]   hi_sum;

    // Stage 1 frees up in the same cycle stage 2 takes its contents.
    always_comb begin
        s2_load  = v1_q & (~v2_q | out_ready);
        in_ready = ~v1_q | s2_load;
        s1_load  = in_valid & in_ready;
        v2_d     = s2_load | (v2_q & ~out_ready);
        v1_d     = s1_load | (v1_q & ~s2_load);
    end

    // Low half resolves in stage 1; its carry-out feeds the high-half add.
    always_comb begin
        lo_sum = {1'b0, in_sum[LO-1:0]} + {1'b0, in_carry[LO-1:0]};
        hi_sum = {1'b0, hs1_q} + {1'b0, hc1_q} + {{HI{1'b0}}, c1_q};
    end

    always_comb begin
        lo1_d  = lo1_q;
        c1_d   = c1_q;
        hs1_d  = hs1_q;
        hc1_d  = hc1_q;
        prod_d = prod_q;
        ovf_d  = ovf_q;
        if (s1_load) begin
            lo1_d = lo_sum[LO-1:0];
            c1_d  = lo_sum[LO];
            hs1_d = in_sum[W-1:LO];
            hc1_d = in_carry[W-1:LO];
        end
        if (s2_load) begin
            prod_d = {hi_sum[HI-1:0], lo1_q};
            ovf_d  = hi_sum[HI];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            lo1_q  <= '0;
            c1_q   <= 1'b0;
            hs1_q  <= '0;
            hc1_q  <= '0;
            prod_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            lo1_q  <= lo1_d;
            c1_q   <= c1_d;
            hs1_q  <= hs1_d;
            hc1_q  <= hc1_d;
            prod_q <= prod_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_valid = v2_q;
    assign out_prod  = prod_q;
    assign out_ovf   = ovf_q;
    assign busy      = v1_q | v2_q;

endmodule
